// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: splits one word/half/byte access into byte-wide
// req/ack beats, reassembles loads little-endian and extends them.
module lsu_bus_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        length,
  input  logic              sign,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d, last_q, last_d, len_q, len_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              we_q, we_d, sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d, bytes_q, bytes_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              resp_valid_q, resp_valid_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;
  logic [1:0]        k_next;
  logic [31:0]       load_ext;

  assign accept = req_valid & (memread | memwrite);
  assign k_next = k_q + 2'd1;

  // Stall drops in DONE so the pipeline advances and the access is not re-accepted.
  assign stall = (state_q == StXfer) || ((state_q == StIdle) && accept);

  always_comb begin
    unique case (len_q)
      2'b01:   load_ext = {{24{sign_q & bytes_d[7]}}, bytes_d[7:0]};
      2'b10:   load_ext = {{16{sign_q & bytes_d[15]}}, bytes_d[15:0]};
      default: load_ext = bytes_d;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    last_d       = last_q;
    len_d        = len_q;
    tmo_d        = tmo_q;
    we_d         = we_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    bytes_d      = bytes_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (length == 2'b11) begin
            state_d      = StDone;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d     = StXfer;
            we_d        = memwrite;
            sign_d      = sign;
            len_d       = length;
            wdata_d     = wdata;
            bytes_d     = '0;
            k_d         = 2'd0;
            tmo_d       = '0;
            last_d      = (length == 2'b00) ? 2'd3 : (length == 2'b10) ? 2'd1 : 2'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = memwrite;
            bus_addr_d  = address;
            bus_wdata_d = wdata[7:0];
          end
        end
      end
      StXfer: begin
        if (bus_ack) begin
          bytes_d[{k_q, 3'b000} +: 8] = bus_rdata;
          tmo_d = '0;
          if (k_q == last_q) begin
            state_d      = StDone;
            bus_req_d    = 1'b0;
            bus_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            rdata_d      = we_q ? 32'd0 : load_ext;
          end else begin
            k_d         = k_next;
            bus_addr_d  = bus_addr_q + ADDR_W'(1);
            bus_wdata_d = wdata_q[{k_next, 3'b000} +: 8];
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          // Limit reached with no ack this cycle: abort the access.
          state_d      = StDone;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          rdata_d      = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      last_q       <= '0;
      len_q        <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      wdata_q      <= '0;
      bytes_q      <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_q       <= last_d;
      len_q        <= len_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      bytes_q      <= bytes_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
